// File: rtl/uart_pkg.sv
// Shared definitions for the UART framing blocks: FSM encoding and frame format constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_PLD  = 3'd3,
    ST_CHK  = 3'd4
  } frm_state_e;

  localparam logic [7:0] FRM_HEADER   = 8'hA5;
  localparam int         FRM_OVERHEAD = 3;  // HEADER + SEQ + CHK around the payload

endpackage

// File: rtl/uart_frm_chk.sv
// XOR checksum accumulator for UART frames; shared by the TX generator and the RX checker.
module uart_frm_chk #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] byte_i,
  output logic [W-1:0] chk_o
);

  logic [W-1:0] chk_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      chk_q <= '0;
    end else if (en_i) begin
      chk_q <= chk_q ^ byte_i;
    end
  end

  assign chk_o = chk_q;

endmodule

// File: rtl/uart_tx_frame_gen.sv
// Frames one payload word as {HEADER, SEQ, payload LSB-first, CHK} onto a byte stream
// with vld/rdy back-pressure towards the UART TX controller.
module uart_tx_frame_gen
  import uart_pkg::*;
#(
  parameter int         DLY        = 1,
  parameter int         DATA_WIDTH = 8,
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] HEADER     = FRM_HEADER
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [WORD_BYTES*8-1:0] word_data_i,
  input  logic                    word_vld_i,
  output logic                    word_rdy_o,
  output logic [DATA_WIDTH-1:0]   ur_tx_ctrl_data_o,
  output logic                    ur_tx_ctrl_vld_o,
  input  logic                    ur_tx_ctrl_rdy_i,
  output logic                    busy_o,
  output logic [15:0]             frame_cnt_o
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  if (DATA_WIDTH != 8 || WORD_BYTES < 1 || WORD_BYTES > 16 || DLY < 0) begin : g_param_err
    $error("uart_tx_frame_gen: unsupported parameter set");
  end

  frm_state_e              state_q, state_nxt;
  logic [IDX_W-1:0]        idx_q;
  logic [WORD_BYTES*8-1:0] word_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    vld_q;
  logic [7:0]              seq_q;
  logic [15:0]             frame_cnt_q;
  logic [DATA_WIDTH-1:0]   chk;

  logic word_xfer, byte_xfer, idx_last, chk_en;

  assign word_xfer = word_vld_i & word_rdy_o;
  assign byte_xfer = vld_q & ur_tx_ctrl_rdy_i;
  assign idx_last  = (idx_q == IDX_W'(WORD_BYTES - 1));
  assign chk_en    = byte_xfer & ((state_q == ST_SEQ) | (state_q == ST_PLD));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state_q;
    word_rdy_o = (state_q == ST_IDLE);
    busy_o     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (word_xfer)             state_nxt = ST_HDR;
      ST_HDR:  if (byte_xfer)             state_nxt = ST_SEQ;
      ST_SEQ:  if (byte_xfer)             state_nxt = ST_PLD;
      ST_PLD:  if (byte_xfer && idx_last) state_nxt = ST_CHK;
      ST_CHK:  if (byte_xfer)             state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // The output register is loaded with the byte of the state being entered, so a
  // state's byte is valid on the first cycle after entry and holds through stalls.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      seq_q       <= 8'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        ST_IDLE: if (word_xfer) begin
          data_q <= HEADER;
          vld_q  <= 1'b1;
        end
        ST_HDR: if (byte_xfer) data_q <= seq_q;
        ST_SEQ: if (byte_xfer) begin
          data_q <= word_q[DATA_WIDTH-1:0];
          idx_q  <= '0;
        end
        ST_PLD: if (byte_xfer) begin
          if (idx_last) begin
            data_q <= chk ^ data_q;  // last payload byte is still in flight into the accumulator
          end else begin
            data_q <= word_q[DATA_WIDTH-1:0];
            idx_q  <= idx_q + 1'b1;
          end
        end
        ST_CHK: if (byte_xfer) begin
          vld_q       <= 1'b0;
          seq_q       <= seq_q + 8'd1;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the payload shift register has no reset; it is always loaded on a word transfer before use.
  always_ff @(posedge clk_i) begin
    if (word_xfer) begin
      word_q <= word_data_i;
    end else if (chk_en) begin
      word_q <= word_q >> 8;
    end
  end

  uart_frm_chk #(.W(DATA_WIDTH)) u_chk (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (word_xfer),
    .en_i    (chk_en),
    .byte_i  (data_q),
    .chk_o   (chk)
  );

  assign ur_tx_ctrl_data_o = data_q;
  assign ur_tx_ctrl_vld_o  = vld_q;
  assign frame_cnt_o       = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Scoreboard bench for uart_tx_frame_gen: directed frames pushed as expected bytes,
// a negedge monitor pops and compares every transferred byte and checks stall stability.
module tb_uart_tx_frame_gen;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_data = '0;
  logic        word_vld = 1'b0;
  logic        word_rdy;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;

  uart_tx_frame_gen #(.WORD_BYTES(4)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .word_data_i       (word_data),
    .word_vld_i        (word_vld),
    .word_rdy_o        (word_rdy),
    .ur_tx_ctrl_data_o (tx_data),
    .ur_tx_ctrl_vld_o  (tx_vld),
    .ur_tx_ctrl_rdy_i  (tx_rdy),
    .busy_o            (busy),
    .frame_cnt_o       (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] exp_q[$];
  int         xfer_cyc[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         stall_checks = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       bp_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a byte transfers on the next posedge when vld & rdy are seen here.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_checks++;
        check("stall_vld_hold", tx_vld, 1);
        check("stall_data_hold", tx_data, prev_data);
      end
      if (tx_vld && tx_rdy) begin
        xfer_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got %h with no byte expected (cycle %0d)", tx_data, cyc);
        end else begin
          check("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      prev_stall = tx_vld && !tx_rdy;
      prev_data  = tx_data;
    end
  end

  task automatic push7(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    exp_q.push_back(b0); exp_q.push_back(b1); exp_q.push_back(b2); exp_q.push_back(b3);
    exp_q.push_back(b4); exp_q.push_back(b5); exp_q.push_back(b6);
  endtask

  task automatic wait_word_rdy();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!word_rdy && n < 400);
    check("word_rdy_seen", word_rdy, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    @(posedge clk); #1;
    word_data = w;
    word_vld  = 1'b1;
    wait_word_rdy();
    @(posedge clk); #1;
    word_vld  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_frame_done"}, (exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_word_rdy", word_rdy, 1);
    check("rst_vld", tx_vld, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single frame, rdy held high
    xfer_cyc.delete();
    push7(8'hA5, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44);
    send_word(32'h1122_3344);
    wait_done("single");
    check("single_byte_count", xfer_cyc.size(), 7);
    if (xfer_cyc.size() == 7)
      check("single_consecutive", xfer_cyc[6] - xfer_cyc[0], WORD_BYTES_SPAN());
    check("single_frame_cnt", frame_cnt, 1);
    check("single_busy", busy, 0);

    // Back-pressure: rdy pattern 1-0-0 repeating
    bp_run = 1'b1;
    fork
      begin
        int k = 0;
        while (bp_run) begin
          @(posedge clk); #1;
          tx_rdy = (k % 3 == 0);
          k++;
        end
        tx_rdy = 1'b1;
      end
    join_none
    push7(8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11, 8'h45);
    send_word(32'h1122_3344);
    wait_done("backpressure");
    bp_run = 1'b0;
    repeat (3) @(posedge clk);
    check("bp_stalls_seen", (stall_checks > 0), 1);
    check("bp_frame_cnt", frame_cnt, 2);

    // Back-to-back frames with word_vld held high
    xfer_cyc.delete();
    push7(8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h20);
    push7(8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03);
    @(posedge clk); #1;
    word_data = 32'hDEAD_BEEF;
    word_vld  = 1'b1;
    wait_word_rdy();
    @(posedge clk); #1 word_data = 32'h0;
    wait_word_rdy();
    @(posedge clk); #1 word_vld = 1'b0;
    wait_done("b2b");
    check("b2b_byte_count", xfer_cyc.size(), 14);
    if (xfer_cyc.size() == 14) begin
      check("b2b_first_span", xfer_cyc[6] - xfer_cyc[0], 6);
      check("b2b_one_bubble", xfer_cyc[7] - xfer_cyc[6], 2);
      check("b2b_second_span", xfer_cyc[13] - xfer_cyc[7], 6);
    end
    check("b2b_frame_cnt", frame_cnt, 4);

    // word_vld pulse during HDR is ignored
    @(posedge clk); #1 tx_rdy = 1'b0;
    push7(8'hA5, 8'h04, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40);
    send_word(32'h1122_3344);
    word_data = 32'hFFFF_FFFF;
    word_vld  = 1'b1;
    @(posedge clk); #1;
    word_vld  = 1'b0;
    word_data = 32'h0;
    tx_rdy    = 1'b1;
    wait_done("ignore_busy");
    repeat (10) @(negedge clk);
    check("ignore_no_extra_busy", busy, 0);
    check("ignore_frame_cnt", frame_cnt, 5);

    // Reset during payload byte 2
    push7(8'hA5, 8'h05, 8'h44, 8'h33, 8'h00, 8'h00, 8'h00);
    repeat (3) void'(exp_q.pop_back());
    send_word(32'h1122_3344);
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(tx_vld && tx_data == 8'h33) && n < 50);
      check("midrst_reached_pld1", tx_data, 8'h33);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_vld", tx_vld, 0);
    check("midrst_word_rdy", word_rdy, 1);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_no_pending", exp_q.size(), 0);
    push7(8'hA5, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h44);
    send_word(32'h1122_3344);
    wait_done("after_rst");
    check("after_rst_frame_cnt", frame_cnt, 1);

    // Sequence wrap over 256 zero frames
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int s = 0; s < 256; s++) begin
      push7(8'hA5, 8'(s), 8'h00, 8'h00, 8'h00, 8'h00, 8'(s));
      send_word(32'h0);
      wait_done("wrap_loop");
    end
    check("wrap_frame_cnt_256", frame_cnt, 256);
    push7(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    send_word(32'h0);
    wait_done("wrap_257");
    check("wrap_frame_cnt_257", frame_cnt, 257);

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic int WORD_BYTES_SPAN();
    return 4 + FRM_OVERHEAD - 1;
  endfunction

endmodule
